phase2_decode: RTL and testbench

Instruction-decode stage of the simple pipeline: holds the IF/ID instruction register, decodes the 16-bit SIMPLE instruction into the phase-3 control bundle (ALUSrc1, ALUSrc2, ALUorshifter, AS_BC, MemRead, Ra, Rb, opcode), and registers that bundle for the execute stage. It is the producing end of the phase-3 control interface. It also owns load-use stall generation, flush-driven bubble insertion and halt detection.

---
 rtl/simple_isa_pkg.sv | 47 ++++
 rtl/phase2_decode_inst_decode.sv | 93 +++++++++
 rtl/phase2_decode.sv | 116 +++++++++++
 tb/tb_phase2_decode.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_isa_pkg.sv
// SIMPLE ISA encodings and the phase-3 control bundle shared by decode and execute.
package simple_isa_pkg;

  localparam logic [1:0] OP1_LD   = 2'b00;
  localparam logic [1:0] OP1_ST   = 2'b01;
  localparam logic [1:0] OP1_LIBR = 2'b10;
  localparam logic [1:0] OP1_CALC = 2'b11;

  localparam logic [3:0] OP3_ADD = 4'b0000;
  localparam logic [3:0] OP3_SUB = 4'b0001;
  localparam logic [3:0] OP3_AND = 4'b0010;
  localparam logic [3:0] OP3_OR  = 4'b0011;
  localparam logic [3:0] OP3_XOR = 4'b0100;
  localparam logic [3:0] OP3_CMP = 4'b0101;
  localparam logic [3:0] OP3_MOV = 4'b0110;
  localparam logic [3:0] OP3_SLL = 4'b1000;
  localparam logic [3:0] OP3_SLR = 4'b1001;
  localparam logic [3:0] OP3_SRL = 4'b1010;
  localparam logic [3:0] OP3_SRA = 4'b1011;
  localparam logic [3:0] OP3_IN  = 4'b1100;
  localparam logic [3:0] OP3_OUT = 4'b1101;
  localparam logic [3:0] OP3_NOP = 4'b1110;
  localparam logic [3:0] OP3_HLT = 4'b1111;

  localparam logic [2:0] OP2_LI    = 3'b000;
  localparam logic [2:0] OP2_B     = 3'b100;
  localparam logic [2:0] OP2_BCOND = 3'b111;

  typedef struct packed {
    logic       ALUSrc1;
    logic       ALUSrc2;
    logic       ALUorshifter;
    logic       AS_BC;
    logic       MemRead;
    logic [2:0] Ra;
    logic [2:0] Rb;
    logic [3:0] opcode;
  } phase3_ctl_t;

  localparam phase3_ctl_t BUBBLE = '0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } dec_state_e;

endpackage

// File: rtl/phase2_decode_inst_decode.sv
// Combinational SIMPLE instruction decoder: control bundle plus source-register usage.
module inst_decode import simple_isa_pkg::*; (
  input  logic [15:0] i_instr,
  output phase3_ctl_t o_ctl,
  output logic        o_real,
  output logic        o_use_a,
  output logic        o_use_b,
  output logic        o_is_hlt
);

  logic [1:0] w_op1;
  logic [2:0] w_a;
  logic [2:0] w_b;
  logic [3:0] w_op3;
  logic       w_unused;

  assign w_op1    = i_instr[15:14];
  assign w_a      = i_instr[13:11];
  assign w_b      = i_instr[10:8];
  assign w_op3    = i_instr[7:4];
  assign w_unused = ^i_instr[3:0];

  always_comb begin
    o_ctl    = BUBBLE;
    o_real   = 1'b0;
    o_use_a  = 1'b0;
    o_use_b  = 1'b0;
    o_is_hlt = 1'b0;
    case (w_op1)
      OP1_CALC: begin
        case (w_op3)
          OP3_ADD, OP3_SUB, OP3_AND, OP3_OR, OP3_XOR, OP3_CMP, OP3_MOV: begin
            o_ctl.opcode = w_op3;
            o_ctl.Ra     = w_a;
            o_ctl.Rb     = w_b;
            o_ctl.AS_BC  = 1'b1;
            o_real       = 1'b1;
            o_use_a      = 1'b1;
            o_use_b      = 1'b1;
          end
          OP3_SLL, OP3_SLR, OP3_SRL, OP3_SRA: begin
            o_ctl.opcode       = w_op3;
            o_ctl.Ra           = w_a;
            o_ctl.Rb           = w_b;
            o_ctl.AS_BC        = 1'b1;
            o_ctl.ALUorshifter = 1'b1;
            o_ctl.ALUSrc2      = 1'b1;
            o_real             = 1'b1;
            o_use_a            = 1'b1;
            o_use_b            = 1'b1;
          end
          OP3_IN, OP3_OUT: begin
            o_ctl.opcode = w_op3;
            o_ctl.Ra     = w_a;
            o_ctl.Rb     = w_b;
            o_ctl.AS_BC  = 1'b1;
            o_real       = 1'b1;
            o_use_a      = (w_op3 == OP3_OUT);
            o_use_b      = (w_op3 == OP3_OUT);
          end
          OP3_HLT: o_is_hlt = 1'b1;
          // NOP and the unassigned op3 slot both decode to a bubble
          default: o_real = 1'b0;
        endcase
      end
      OP1_LD: begin
        o_ctl.MemRead = 1'b1;
        o_ctl.ALUSrc2 = 1'b1;
        o_ctl.Ra      = w_a;
        o_ctl.Rb      = w_b;
        o_real        = 1'b1;
        o_use_b       = 1'b1;
      end
      OP1_ST: begin
        o_ctl.ALUSrc2 = 1'b1;
        o_ctl.Ra      = w_a;
        o_ctl.Rb      = w_b;
        o_real        = 1'b1;
        o_use_a       = 1'b1;
        o_use_b       = 1'b1;
      end
      default: begin
        o_ctl.ALUSrc1 = 1'b1;
        o_ctl.ALUSrc2 = 1'b1;
        o_ctl.Rb      = w_b;
        o_ctl.opcode  = (w_a == OP2_LI) ? OP3_MOV : OP3_ADD;
        o_real        = 1'b1;
        o_use_b       = (w_a == OP2_BCOND);
      end
    endcase
  end

endmodule

// File: rtl/phase2_decode.sv
// Decode stage: IF/ID register, control-bundle register, load-use stall, flush bubbles, halt.
module phase2_decode import simple_isa_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr_i,
  input  logic        instr_valid_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        halted_o,
  output logic        valid_o,
  output logic        ALUSrc1_o,
  output logic        ALUSrc2_o,
  output logic        ALUorshifter_o,
  output logic        AS_BC_o,
  output logic        MemRead_o,
  output logic [2:0]  Ra_o,
  output logic [2:0]  Rb_o,
  output logic [3:0]  opcode_o
);

  dec_state_e  r_state;
  dec_state_e  w_state_nxt;
  logic [15:0] r_id_instr_p1;
  logic        r_id_vld_p1;
  phase3_ctl_t r_ctl_p2;
  logic        r_vld_p2;

  phase3_ctl_t w_dec_ctl;
  logic        w_dec_real;
  logic        w_use_a;
  logic        w_use_b;
  logic        w_is_hlt;
  logic        w_hazard;
  logic        w_halted;
  logic        w_stall;
  logic        w_kill;
  phase3_ctl_t w_ctl_nxt;
  logic        w_vld_nxt;

  inst_decode u_dec (
    .i_instr  (r_id_instr_p1),
    .o_ctl    (w_dec_ctl),
    .o_real   (w_dec_real),
    .o_use_a  (w_use_a),
    .o_use_b  (w_use_b),
    .o_is_hlt (w_is_hlt)
  );

  // A load in execute whose destination is read by the instruction now in decode.
  assign w_hazard = r_vld_p2 & r_ctl_p2.MemRead & r_id_vld_p1 &
                    ((w_use_a & (r_ctl_p2.Ra == r_id_instr_p1[13:11])) |
                     (w_use_b & (r_ctl_p2.Ra == r_id_instr_p1[10:8])));
  assign w_halted = (r_state == ST_HALT);
  assign w_stall  = w_halted | w_hazard;
  assign w_kill   = flush_i & ~w_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ctl_nxt   = BUBBLE;
    w_vld_nxt   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!w_kill) begin
          if (r_id_vld_p1 && w_is_hlt) begin
            w_state_nxt = ST_HALT;
          end else if (!w_hazard && r_id_vld_p1 && w_dec_real) begin
            w_ctl_nxt = w_dec_ctl;
            w_vld_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_HALT;
    endcase
  end

  // ---- IF/ID boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_instr_p1 <= '0;
      r_id_vld_p1   <= 1'b0;
    end else begin
      if (w_kill)        r_id_vld_p1 <= 1'b0;
      else if (!w_stall) r_id_vld_p1 <= instr_valid_i;
      if (!w_stall)      r_id_instr_p1 <= instr_i;
    end
  end

  // ---- ID/EX boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl_p2 <= BUBBLE;
      r_vld_p2 <= 1'b0;
    end else begin
      r_ctl_p2 <= w_ctl_nxt;
      r_vld_p2 <= w_vld_nxt;
    end
  end

  assign stall_o        = w_stall;
  assign halted_o       = w_halted;
  assign valid_o        = r_vld_p2;
  assign ALUSrc1_o      = r_ctl_p2.ALUSrc1;
  assign ALUSrc2_o      = r_ctl_p2.ALUSrc2;
  assign ALUorshifter_o = r_ctl_p2.ALUorshifter;
  assign AS_BC_o        = r_ctl_p2.AS_BC;
  assign MemRead_o      = r_ctl_p2.MemRead;
  assign Ra_o           = r_ctl_p2.Ra;
  assign Rb_o           = r_ctl_p2.Rb;
  assign opcode_o       = r_ctl_p2.opcode;

endmodule

// File: tb/tb_phase2_decode.sv
// Scoreboard bench for phase2_decode: directed test-plan sequences plus randomized streams.
module tb_phase2_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr_i = '0;
  logic        instr_valid_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_o, halted_o, valid_o;
  logic        ALUSrc1_o, ALUSrc2_o, ALUorshifter_o, AS_BC_o, MemRead_o;
  logic [2:0]  Ra_o, Rb_o;
  logic [3:0]  opcode_o;

  phase2_decode dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_i        (instr_i),
    .instr_valid_i  (instr_valid_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .halted_o       (halted_o),
    .valid_o        (valid_o),
    .ALUSrc1_o      (ALUSrc1_o),
    .ALUSrc2_o      (ALUSrc2_o),
    .ALUorshifter_o (ALUorshifter_o),
    .AS_BC_o        (AS_BC_o),
    .MemRead_o      (MemRead_o),
    .Ra_o           (Ra_o),
    .Rb_o           (Rb_o),
    .opcode_o       (opcode_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v, s1, s2, sh, asbc, mr;
    logic [2:0] ra, rb;
    logic [3:0] op;
    logic       st, hl;
  } obs_t;

  obs_t        sb_q[$];
  logic [15:0] prog[$];
  int          checks = 0;
  int          failures = 0;

  // Reference machine state: decode slot, last issued bundle, halted flag
  logic        m_idv;
  logic [15:0] m_idi;
  logic        m_halt;
  obs_t        m_out;

  // Classify by mnemonic, then fill the bundle; src is the set of registers read.
  function automatic obs_t ref_dec(input logic [15:0] w, output logic is_real,
                                   output logic is_hlt, output logic [7:0] src);
    obs_t o;
    int op1, a, b, f;
    op1 = int'(w[15:14]); a = int'(w[13:11]); b = int'(w[10:8]); f = int'(w[7:4]);
    o = '0; is_real = 1'b0; is_hlt = 1'b0; src = '0;
    if (op1 == 3) begin
      if (f <= 6 || (f >= 8 && f <= 13)) begin
        is_real = 1'b1;
        o.op = 4'(f); o.ra = 3'(a); o.rb = 3'(b); o.asbc = 1'b1;
        if (f >= 8 && f <= 11) begin o.sh = 1'b1; o.s2 = 1'b1; end
        if (f != 12) src = (8'd1 << a) | (8'd1 << b);
      end else if (f == 15) begin
        is_hlt = 1'b1;
      end
    end else if (op1 == 0) begin
      is_real = 1'b1; o.mr = 1'b1; o.s2 = 1'b1; o.ra = 3'(a); o.rb = 3'(b);
      src = 8'd1 << b;
    end else if (op1 == 1) begin
      is_real = 1'b1; o.s2 = 1'b1; o.ra = 3'(a); o.rb = 3'(b);
      src = (8'd1 << a) | (8'd1 << b);
    end else begin
      is_real = 1'b1; o.s1 = 1'b1; o.s2 = 1'b1; o.rb = 3'(b);
      o.op = (a == 0) ? 4'd6 : 4'd0;
      src = (a == 7) ? (8'd1 << b) : 8'd0;
    end
    o.v = is_real;
    return o;
  endfunction

  function automatic logic m_stall();
    logic r, h;
    logic [7:0] s;
    obs_t d;
    d = ref_dec(m_idi, r, h, s);
    return m_halt | (m_out.v & m_out.mr & m_idv & s[m_out.ra]);
  endfunction

  function automatic obs_t dut_obs();
    obs_t a;
    a = {valid_o, ALUSrc1_o, ALUSrc2_o, ALUorshifter_o, AS_BC_o, MemRead_o,
         Ra_o, Rb_o, opcode_o, stall_o, halted_o};
    return a;
  endfunction

  task automatic model_reset();
    m_idv = 1'b0; m_idi = '0; m_halt = 1'b0; m_out = '0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference machine, queue the expected outputs.
  task automatic step(input logic rstn, input logic use_iv, input logic fl);
    obs_t e, d;
    logic r, h, st, iv;
    logic [7:0] s;
    if (!rstn) begin
      instr_valid_i = 1'($urandom);
      instr_i = 16'($urandom);
      flush_i = 1'($urandom);
      if (rst_n) begin
        rst_n = 1'b0;
        #1;
        chk("async_reset_clear", int'(dut_obs()), 0);
      end
      rst_n = 1'b0;
      model_reset();
      sb_q.push_back('0);
    end else begin
      rst_n = 1'b1;
      st = m_stall();
      iv = use_iv && (prog.size() > 0);
      instr_i = iv ? prog[0] : 16'($urandom);
      instr_valid_i = iv;
      flush_i = fl;
      d = ref_dec(m_idi, r, h, s);
      if (m_halt) begin
        m_out = '0;
      end else if (fl) begin
        m_out = '0; m_idv = 1'b0;
        if (!st) m_idi = instr_i;
      end else if (m_idv && h) begin
        m_halt = 1'b1; m_out = '0;
        if (!st) begin m_idv = iv; m_idi = instr_i; end
      end else if (st) begin
        m_out = '0;
      end else begin
        m_out = (m_idv && r) ? d : '0;
        m_idv = iv; m_idi = instr_i;
      end
      if (!st && iv) void'(prog.pop_front());
      e = m_out;
      e.st = m_stall();
      e.hl = m_halt;
      sb_q.push_back(e);
    end
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [1:0] op1;
    logic [3:0] f;
    int r;
    r = int'($urandom % 10);
    op1 = (r < 3) ? 2'b00 : (r == 3) ? 2'b01 : (r == 4) ? 2'b10 : 2'b11;
    f = 4'($urandom);
    if (f == 4'hF && ($urandom % 4) != 0) f = 4'h0;
    if (op1 == 2'b10 && ($urandom % 2) == 0) return {op1, 3'b111, 3'($urandom % 4), 8'($urandom)};
    return {op1, 3'($urandom % 4), 3'($urandom % 4), f, 4'($urandom)};
  endfunction

  // Monitor: one expected record per clock, compared away from the active edge
  initial begin
    obs_t e, a;
    wait (sb_q.size() > 0);
    forever begin
      @(negedge clk);
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow t=%0t", $time);
      end else begin
        e = sb_q.pop_front();
        a = dut_obs();
        if (a !== e) begin
          failures++;
          $display("FAIL sb_cycle t=%0t act=%h exp=%h", $time, a, e);
        end
      end
    end
  end

  initial begin
    int nst, nv;
    logic v2, v3;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", int'(dut_obs()), 0);
    step(1'b0, 1'b0, 1'b0);

    // ADD R1,R2 after reset
    prog.push_back(16'hCA00);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("add_valid", int'(valid_o), 1);
    chk("add_ra", int'(Ra_o), 1);
    chk("add_rb", int'(Rb_o), 2);
    chk("add_asbc", int'(AS_BC_o), 1);
    chk("add_opcode", int'(opcode_o), 0);
    step(1'b1, 1'b0, 1'b0);

    // LD R3,0(R4) then dependent ADD R3,R5
    prog.push_back(16'h1C00); prog.push_back(16'hDD00);
    nst = 0; nv = 0;
    repeat (6) begin
      step(1'b1, 1'b1, 1'b0);
      nst += int'(stall_o); nv += int'(valid_o);
    end
    chk("ldu_stall_cycles", nst, 1);
    chk("ldu_valid_count", nv, 2);

    // LD R3 then independent ADD R1,R2
    prog.push_back(16'h1C00); prog.push_back(16'hCA00);
    nst = 0;
    step(1'b1, 1'b1, 1'b0); nst += int'(stall_o);
    step(1'b1, 1'b1, 1'b0); nst += int'(stall_o); v2 = valid_o;
    step(1'b1, 1'b1, 1'b0); nst += int'(stall_o); v3 = valid_o;
    chk("nodep_stall_cycles", nst, 0);
    chk("nodep_back_to_back", int'({v2, v3}), 3);
    step(1'b1, 1'b0, 1'b0);

    // Flush during a load-use stall
    prog.push_back(16'h1C00); prog.push_back(16'hDD00);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("flush_pre_stall", int'(stall_o), 1);
    step(1'b1, 1'b1, 1'b1);
    chk("flush_stall_drop", int'(stall_o), 0);
    chk("flush_bubble", int'(valid_o), 0);
    nv = 0;
    repeat (4) begin step(1'b1, 1'b1, 1'b0); nv += int'(valid_o); end
    chk("flush_dep_killed", nv, 0);

    // HLT then ignored traffic and flushes, then reset
    prog.push_back(16'hC0F0); prog.push_back(16'hCA00); prog.push_back(16'hCA00);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("hlt_halted", int'(halted_o), 1);
    chk("hlt_stall", int'(stall_o), 1);
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'(i % 2));
      nv += int'(valid_o);
    end
    chk("hlt_frozen_valid", nv, 0);
    chk("hlt_still_halted", int'(halted_o), 1);
    step(1'b0, 1'b0, 1'b0);
    prog.delete();
    step(1'b1, 1'b0, 1'b0);
    chk("hlt_reset_exit", int'(halted_o), 0);

    // SLL R2,3
    prog.push_back(16'hC283);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("sll_shifter", int'(ALUorshifter_o), 1);
    chk("sll_src2", int'(ALUSrc2_o), 1);
    chk("sll_opcode", int'(opcode_o), 8);
    chk("sll_asbc", int'(AS_BC_o), 1);

    // Randomized traffic with flushes, idle cycles and occasional resets
    for (int n = 0; n < 2500; n++) begin
      logic do_rst, fl, uiv;
      while (prog.size() < 2) prog.push_back(rand_instr());
      do_rst = m_halt ? (($urandom % 6) == 0) : (($urandom % 80) == 0);
      fl  = (($urandom % 12) == 0);
      uiv = (($urandom % 8) != 0);
      step(!do_rst, uiv, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
